// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first subtractor computing A-B-Bin
//
// Optional feature macro: SERIAL_SUB_FLAGS_EN adds the registered Zero/Neg/Ovf outputs.
//
// Ports:
//   clk    in   clock, all state changes on its rising edge
//   rst    in   asynchronous active-high reset
//   Start  in   operation request, sampled only while Ready=1
//   A      in   minuend, captured on accepted Start
//   B      in   subtrahend, captured on accepted Start
//   Bin    in   borrow-in, captured on accepted Start
//   Ready  out  high only while idle
//   Diff   out  A-B-Bin modulo 2^WIDTH, held from Done until the next accepted Start
//   Bout   out  final borrow-out
//   Done   out  one-cycle pulse marking Diff/Bout valid
//   Zero   out  (flags build) Diff==0
//   Neg    out  (flags build) Diff[WIDTH-1]
//   Ovf    out  (flags build) signed overflow of the subtraction
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             Ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
`ifdef SERIAL_SUB_FLAGS_EN
    output logic             Zero,
    output logic             Neg,
    output logic             Ovf,
`endif
    output logic             Done
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bit_d;
`ifdef SERIAL_SUB_FLAGS_EN
    // Operand sign bits are lost as the shift registers drain, so keep them.
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             ovf_q, ovf_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_SUB_FLAGS_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_SUB_FLAGS_EN
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        diff_d  = diff_q;
        br_d    = br_q;
        bout_d  = bout_q;
        cnt_d   = cnt_q;
        bit_d   = 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (Start) begin
                    a_d     = A;
                    b_d     = B;
                    br_d    = Bin;
                    cnt_d   = '0;
                    state_d = SHIFT;
`ifdef SERIAL_SUB_FLAGS_EN
                    a_msb_d = A[WIDTH-1];
                    b_msb_d = B[WIDTH-1];
`endif
                end
            end
            SHIFT: begin
                if (cnt_q == CW'(WIDTH)) begin
                    // All bits consumed: publish the result on the way to DONE,
                    // which lands Done one cycle after the WIDTH-th bit.
                    diff_d  = res_q;
                    bout_d  = br_q;
                    state_d = DONE;
`ifdef SERIAL_SUB_FLAGS_EN
                    zero_d  = (res_q == '0);
                    neg_d   = res_q[WIDTH-1];
                    ovf_d   = (a_msb_q != b_msb_q) && (res_q[WIDTH-1] != a_msb_q);
`endif
                end else begin
                    bit_d = a_q[0] ^ b_q[0] ^ br_q;
                    br_d  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
                    a_d   = a_q >> 1;
                    b_d   = b_q >> 1;
                    res_d = {bit_d, res_q[WIDTH-1:1]};
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign Ready = (state_q == IDLE);
    assign Done  = (state_q == DONE);
    assign Diff  = diff_q;
    assign Bout  = bout_q;
`ifdef SERIAL_SUB_FLAGS_EN
    assign Zero  = zero_q;
    assign Neg   = neg_q;
    assign Ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor at WIDTH=8
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             Start = 1'b0;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic             Bin = 1'b0;
    logic             Ready;
    logic [WIDTH-1:0] Diff;
    logic             Bout;
    logic             Done;
`ifdef SERIAL_SUB_FLAGS_EN
    logic             Zero;
    logic             Neg;
    logic             Ovf;
`endif

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .Start (Start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .Ready (Ready),
        .Diff  (Diff),
        .Bout  (Bout),
`ifdef SERIAL_SUB_FLAGS_EN
        .Zero  (Zero),
        .Neg   (Neg),
        .Ovf   (Ovf),
`endif
        .Done  (Done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] diff;
        logic             bout;
        logic             zero;
        logic             neg;
        logic             ovf;
        int               cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Monitor: every Done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && Done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("diff", 32'(Diff), 32'(e.diff));
                check("bout", 32'(Bout), 32'(e.bout));
                check("latency_cycle", 32'(cyc), 32'(e.cyc));
`ifdef SERIAL_SUB_FLAGS_EN
                check("zero", 32'(Zero), 32'(e.zero));
                check("neg", 32'(Neg), 32'(e.neg));
                check("ovf", 32'(Ovf), 32'(e.ovf));
`endif
            end
        end
    end

    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic bin, input bit push,
                            input logic [WIDTH-1:0] ediff, input logic ebout,
                            input logic ez, input logic en, input logic eo);
        int guard;
        exp_t e;
        guard = 0;
        @(negedge clk);
        while (!Ready && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_start", 32'(Ready), 32'd1);
        A = a;
        B = b;
        Bin = bin;
        Start = 1'b1;
        @(posedge clk);
        #1;
        if (push) begin
            e.diff = ediff;
            e.bout = ebout;
            e.zero = ez;
            e.neg  = en;
            e.ovf  = eo;
            e.cyc  = cyc + WIDTH + 1;
            exp_q.push_back(e);
        end
        @(negedge clk);
        Start = 1'b0;
        // Captured operands must be immune to later input activity.
        A = ~a;
        B = ~b;
        Bin = ~bin;
    endtask

    task automatic wait_done();
        int i;
        for (i = 0; i < 30; i++) begin
            if (Done) break;
            @(negedge clk);
        end
        if (!Done) check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #1;
        check("rst_ready", 32'(Ready), 32'd1);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_diff", 32'(Diff), 32'd0);
        check("rst_bout", 32'(Bout), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        start_op(8'h05, 8'h03, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
        check("ready_low_shift", 32'(Ready), 32'd0);
        wait_done();
        check("ready_low_done", 32'(Ready), 32'd0);

        start_op(8'h03, 8'h05, 1'b0, 1'b1, 8'hFE, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_done();
        start_op(8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_done();
        start_op(8'h2A, 8'h2A, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_done();
        start_op(8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0, 1'b1, 1'b1);
        wait_done();

        // Start pulsed mid-operation must be ignored.
        start_op(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("ready_low_mid", 32'(Ready), 32'd0);
        A = 8'hFF;
        B = 8'h00;
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        wait_done();
        check("ready_low_done2", 32'(Ready), 32'd0);
        @(negedge clk);
        A = 8'h55;
        B = 8'h11;
        check("ready_after_done", 32'(Ready), 32'd1);
        check("diff_hold", 32'(Diff), 32'h0F);
        repeat (2) @(negedge clk);
        check("diff_hold2", 32'(Diff), 32'h0F);

        // Asynchronous reset mid-shift: aborts with no Done.
        start_op(8'hC3, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_ready", 32'(Ready), 32'd1);
        check("arst_done", 32'(Done), 32'd0);
        check("arst_diff", 32'(Diff), 32'd0);
        check("arst_bout", 32'(Bout), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("no_done_after_abort", 32'(exp_q.size()), 32'd0);

        start_op(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_done();

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand width in bits; legal range is 2..32.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-004 Start  input  1  SHALL request an operation; sampled only while Ready=1.
REQ-005 A  input  WIDTH  SHALL be the minuend, captured on the accepted Start.
REQ-006 B  input  WIDTH  SHALL be the subtrahend, captured on the accepted Start.
REQ-007 Bin  input  1  SHALL be the borrow-in, captured on the accepted Start.
REQ-008 Ready  output  1  SHALL be high only in state IDLE.
REQ-009 Diff  output  WIDTH  SHALL be the result A-B-Bin modulo 2^WIDTH.
REQ-010 Bout  output  1  SHALL be the final borrow-out (1 when A < B+Bin unsigned).
REQ-011 Done  output  1  SHALL be a one-cycle pulse marking Diff/Bout valid.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT and DONE, held in a registered state variable.
REQ-013 IDLE with Start=1: capture A, B and Bin into shift/borrow registers, clear bit counter, go to SHIFT; Start=0: stay in IDLE.
REQ-014 SHIFT SHALL process exactly one bit per cycle, LSB first: d = a XOR b XOR br; br_next = (~a & b) | (~(a XOR b) & br).
REQ-015 Each d SHALL shift into the MSB of the result register, so after WIDTH SHIFT cycles bit 0 sits in Diff[0].
REQ-016 The bit counter SHALL be $clog2(WIDTH)+1 bits wide; after the WIDTH-th SHIFT cycle the FSM SHALL go to DONE.
REQ-017 DONE SHALL last exactly one cycle with Done=1, then return to IDLE.
REQ-018 Latency: Start accepted at edge N SHALL give Done=1 in the cycle after edge N+WIDTH+1.
REQ-019 Diff and Bout SHALL hold their final values from DONE until the next accepted Start; during SHIFT their value is unspecified.
REQ-020 Start while Ready=0, in SHIFT or DONE, SHALL be ignored with no effect on the operation in flight.
REQ-021 Changes on A, B or Bin after capture SHALL not affect the result.
REQ-022 Back-to-back operations SHALL be possible with one IDLE cycle between Done and the next capture.

Reset
REQ-023 rst=1 SHALL immediately force state IDLE, Ready=1, Done=0, Diff=0, Bout=0, counter=0 and borrow=0, regardless of clock.
REQ-024 Reset during SHIFT or DONE SHALL abort the operation with no Done pulse; the first Start after rst deasserts SHALL be accepted normally.

Configuration
REQ-025 Macro SERIAL_SUB_FLAGS_EN defined: extra outputs Zero (Diff==0), Neg (Diff[WIDTH-1]) and Ovf (signed overflow: A[msb]!=B[msb] and Diff[msb]!=A[msb]) SHALL be registered with Diff and be valid under the same rules, reset to 0.
REQ-026 Macro SERIAL_SUB_FLAGS_EN undefined: Zero, Neg and Ovf SHALL not exist as ports and no flag logic SHALL be built; all other behaviour is identical.

Verification (WIDTH=8)
REQ-027 A=0x05, B=0x03, Bin=0, Start pulse -> Done exactly 9 cycles after capture edge, Diff=0x02, Bout=0.
REQ-028 A=0x03, B=0x05, Bin=0 -> Diff=0xFE, Bout=1; with flags: Neg=1, Zero=0, Ovf=0.
REQ-029 A=0x00, B=0x00, Bin=1 -> Diff=0xFF, Bout=1; then A=0x2A, B=0x2A, Bin=0 -> Diff=0x00, Bout=0, Zero=1 (flags build).
REQ-030 Start with A=0x10, B=0x01; during SHIFT pulse Start with A=0xFF, B=0x00 -> single Done, Diff=0x0F, Ready low until DONE ends.
REQ-031 rst asserted asynchronously mid-SHIFT -> outputs reset at once, no Done; new op A=0x80, B=0x01 -> Diff=0x7F, Bout=0, Ovf=1 (flags build).
